// File: rtl/ula_nibble_seq_if.sv
// Bundles for the nibble sequencer: host-side start/result handshake and the
// connection to the shared 4-bit ALU slice.
interface ula_seq_host_if #(parameter int unsigned NIBBLES = 4);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   op_s;
  logic         op_m;
  logic         op_cin;
  logic [W-1:0] result;
  logic         c_out;
  logic         a_eq_b;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output start, op_a, op_b, op_s, op_m, op_cin, out_ready,
    input  in_ready, result, c_out, a_eq_b, out_valid
  );

  modport slave (
    input  start, op_a, op_b, op_s, op_m, op_cin, out_ready,
    output in_ready, result, c_out, a_eq_b, out_valid
  );
endinterface

interface ula_slice_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_m;
  logic       alu_cin;
  logic [3:0] alu_f;
  logic       alu_cout;
  logic       alu_aeqb;

  modport master (
    output alu_a, alu_b, alu_s, alu_m, alu_cin,
    input  alu_f, alu_cout, alu_aeqb
  );

  modport slave (
    input  alu_a, alu_b, alu_s, alu_m, alu_cin,
    output alu_f, alu_cout, alu_aeqb
  );
endinterface

// File: rtl/ula_nibble_seq.sv
// Runs a W-bit operation through one 4-bit ALU slice, LS nibble first, one
// nibble per clock, chaining the carry and assembling the wide result.
module ula_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ula_seq_host_if.slave     host,
  ula_slice_if.master       alu
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  // Select codes whose raw slice carry is active-low in arithmetic mode.
  localparam logic [15:0] INV_MASK = 16'hC7CC;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state,     state_nxt;
  logic [IDX_W-1:0] idx,       idx_nxt;
  logic [W-1:0]     a_rot,     a_rot_nxt;
  logic [W-1:0]     b_rot,     b_rot_nxt;
  logic [3:0]       s_reg,     s_reg_nxt;
  logic             m_reg,     m_reg_nxt;
  logic             carry,     carry_nxt;
  logic             eq_acc,    eq_acc_nxt;
  logic [W-1:0]     result_q,  result_nxt;
  logic             c_out_q,   c_out_nxt;
  logic             a_eq_b_q,  a_eq_b_nxt;
  logic             valid_q,   valid_nxt;
  logic             ready_q,   ready_nxt;

  logic [W-1:0]     a_step_c, b_step_c;
  logic             inv_c, true_carry_c;

  // Operands rotate one nibble per RUN edge so nibble 0 is back in place after
  // the last nibble; the slice inputs then come straight from flops.
  generate
    if (NIBBLES > 1) begin : g_rot
      assign a_step_c = {a_rot[3:0], a_rot[W-1:4]};
      assign b_step_c = {b_rot[3:0], b_rot[W-1:4]};
    end else begin : g_norot
      assign a_step_c = a_rot;
      assign b_step_c = b_rot;
    end
  endgenerate

  assign inv_c        = INV_MASK[s_reg] & ~m_reg;
  assign true_carry_c = ~m_reg & (alu.alu_cout ^ inv_c);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_rot    <= '0;
      b_rot    <= '0;
      s_reg    <= '0;
      m_reg    <= 1'b0;
      carry    <= 1'b0;
      eq_acc   <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      a_eq_b_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      a_rot    <= a_rot_nxt;
      b_rot    <= b_rot_nxt;
      s_reg    <= s_reg_nxt;
      m_reg    <= m_reg_nxt;
      carry    <= carry_nxt;
      eq_acc   <= eq_acc_nxt;
      result_q <= result_nxt;
      c_out_q  <= c_out_nxt;
      a_eq_b_q <= a_eq_b_nxt;
      valid_q  <= valid_nxt;
      ready_q  <= ready_nxt;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    a_rot_nxt  = a_rot;
    b_rot_nxt  = b_rot;
    s_reg_nxt  = s_reg;
    m_reg_nxt  = m_reg;
    carry_nxt  = carry;
    eq_acc_nxt = eq_acc;
    result_nxt = result_q;
    c_out_nxt  = c_out_q;
    a_eq_b_nxt = a_eq_b_q;
    valid_nxt  = valid_q;
    ready_nxt  = ready_q;

    case (state)
      IDLE: begin
        if (host.start) begin
          state_nxt  = RUN;
          idx_nxt    = '0;
          a_rot_nxt  = host.op_a;
          b_rot_nxt  = host.op_b;
          s_reg_nxt  = host.op_s;
          m_reg_nxt  = host.op_m;
          carry_nxt  = host.op_cin & ~host.op_m;
          eq_acc_nxt = 1'b1;
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end
      end

      RUN: begin
        result_nxt[{idx, 2'b00} +: 4] = alu.alu_f;
        eq_acc_nxt = eq_acc & alu.alu_aeqb;
        carry_nxt  = true_carry_c;
        a_rot_nxt  = a_step_c;
        b_rot_nxt  = b_step_c;
        if (idx == LAST_IDX) begin
          state_nxt  = DONE;
          c_out_nxt  = alu.alu_cout & ~m_reg;
          a_eq_b_nxt = eq_acc & alu.alu_aeqb;
          valid_nxt  = 1'b1;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end

      DONE: begin
        if (host.out_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          ready_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase
  end

  assign host.in_ready  = ready_q;
  assign host.result    = result_q;
  assign host.c_out     = c_out_q;
  assign host.a_eq_b    = a_eq_b_q;
  assign host.out_valid = valid_q;

  assign alu.alu_a   = a_rot[3:0];
  assign alu.alu_b   = b_rot[3:0];
  assign alu.alu_s   = s_reg;
  assign alu.alu_m   = m_reg;
  assign alu.alu_cin = carry;

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Bench for ula_nibble_seq: a behavioural slice model closes the loop and a
// whole-word reference model supplies every expected value.
module tb_ula_nibble_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ula_seq_host_if #(.NIBBLES(NIBBLES)) host ();
  ula_slice_if                         alu  ();

  ula_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host),
    .alu   (alu)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic inv_of(input logic [3:0] s);
    return s inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd14, 4'd15};
  endfunction

  // Returns {true carry out of bit 'width', result in low 'width' bits}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] s, input logic m,
                                        input logic cin, input int width);
    logic [W:0] mask, la, lb, x, y, sum;
    logic use_cin;
    mask = '1;
    mask = mask >> (W + 1 - width);
    la = {1'b0, a};
    lb = {1'b0, b};
    x = la;
    y = '0;
    use_cin = 1'b1;
    if (m) begin
      case (s)
        4'd0:  x = ~la;
        4'd1:  x = ~(la | lb);
        4'd2:  x = ~la & lb;
        4'd3:  x = '0;
        4'd4:  x = ~(la & lb);
        4'd5:  x = ~lb;
        4'd6:  x = la ^ lb;
        4'd7:  x = la & ~lb;
        4'd8:  x = ~la | lb;
        4'd9:  x = ~(la ^ lb);
        4'd10: x = lb;
        4'd11: x = la & lb;
        4'd12: x = '1;
        4'd13: x = la | ~lb;
        4'd14: x = la | lb;
        default: x = la;
      endcase
      return x & mask;
    end
    case (s)
      4'd0:  begin x = la;       use_cin = 1'b0; end
      4'd1:  begin x = la | lb;  use_cin = 1'b0; end
      4'd2:  begin x = la & lb;  use_cin = 1'b0; end
      4'd3:  begin x = ~la;      use_cin = 1'b0; end
      4'd4:  begin x = la ^ lb;  use_cin = 1'b0; end
      4'd5:  y = lb;
      4'd6:  y = ~lb;
      4'd7:  y = '1;
      4'd8:  y = ~lb;
      4'd9:  begin x = ~la; y = lb; end
      4'd10: y = la;
      4'd11: x = la | lb;
      4'd12: y = la & lb;
      4'd13: y = '0;
      4'd14: y = '1;
      default: begin x = la & lb; y = '1; end
    endcase
    sum = (x & mask) + (y & mask) + {{W{1'b0}}, cin & use_cin};
    return {sum[width], W'(sum & mask)};
  endfunction

  // Behavioural 4-bit slice: raw carry uses the inverted sense where listed,
  // logic mode produces a junk carry the sequencer must suppress.
  logic [W:0] slice_r;
  assign slice_r      = ref_op(W'(alu.alu_a), W'(alu.alu_b), alu.alu_s, alu.alu_m, alu.alu_cin, 4);
  assign alu.alu_f    = slice_r[3:0];
  assign alu.alu_cout = alu.alu_m ? ^(alu.alu_a & alu.alu_b) : (slice_r[W] ^ inv_of(alu.alu_s));
  assign alu.alu_aeqb = (alu.alu_a == alu.alu_b);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // True carry entering nibble k, taken from the word-level model.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [3:0] s, input logic m,
                                      input logic cin, input int k);
    logic [W:0] r;
    if (m) return 1'b0;
    if (k == 0) return cin;
    r = ref_op(a, b, s, m, cin, 4 * k);
    return r[W];
  endfunction

  task automatic scramble_ops();
    host.op_a   = W'($urandom);
    host.op_b   = W'($urandom);
    host.op_s   = 4'($urandom);
    host.op_m   = 1'($urandom);
    host.op_cin = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input int hold, input bit early);
    logic [W:0]   r;
    logic [W-1:0] er;
    logic         ec, ee;
    int           waited;
    r  = ref_op(a, b, s, m, cin, W);
    er = r[W-1:0];
    ec = m ? 1'b0 : (r[W] ^ inv_of(s));
    ee = (a == b);

    waited = 0;
    while (host.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk1("in_ready_idle", host.in_ready, 1'b1);

    host.op_a = a; host.op_b = b; host.op_s = s; host.op_m = m; host.op_cin = cin;
    host.start = 1'b1;
    host.out_ready = 1'b0;
    @(negedge clk);
    host.start = 1'b0;

    for (int k = 0; k < int'(NIBBLES); k++) begin
      scramble_ops();
      chk1("run_out_valid", host.out_valid, 1'b0);
      chk1("run_in_ready", host.in_ready, 1'b0);
      chk("run_alu_a", W'(alu.alu_a), W'(a[4*k +: 4]));
      chk("run_alu_b", W'(alu.alu_b), W'(b[4*k +: 4]));
      chk1("run_alu_cin", alu.alu_cin, carry_into(a, b, s, m, cin, k));
      if (early && k == int'(NIBBLES) - 1) host.out_ready = 1'b1;
      host.start = 1'($urandom);
      @(negedge clk);
    end

    chk1("done_out_valid", host.out_valid, 1'b1);
    chk("done_result", host.result, er);
    chk1("done_c_out", host.c_out, ec);
    chk1("done_a_eq_b", host.a_eq_b, ee);
    chk1("done_in_ready", host.in_ready, 1'b0);
    chk("done_alu_a_nib0", W'(alu.alu_a), W'(a[3:0]));

    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        host.start = 1'($urandom);
        scramble_ops();
        @(negedge clk);
        chk1("hold_out_valid", host.out_valid, 1'b1);
        chk("hold_result", host.result, er);
        chk1("hold_c_out", host.c_out, ec);
        chk1("hold_a_eq_b", host.a_eq_b, ee);
        chk1("hold_in_ready", host.in_ready, 1'b0);
      end
      host.out_ready = 1'b1;
    end
    host.start = 1'b0;
    @(negedge clk);
    host.out_ready = 1'b0;
    chk1("xfer_out_valid", host.out_valid, 1'b0);
    chk1("xfer_in_ready", host.in_ready, 1'b1);
    chk("xfer_result_held", host.result, er);
    chk1("xfer_c_out_held", host.c_out, ec);
    chk1("xfer_a_eq_b_held", host.a_eq_b, ee);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    host.start = 1'b0;
    host.out_ready = 1'b0;
    host.op_a = '0; host.op_b = '0; host.op_s = '0; host.op_m = 1'b0; host.op_cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_in_ready", host.in_ready, 1'b1);
    chk1("rst_out_valid", host.out_valid, 1'b0);
    chk("rst_result", host.result, '0);
    chk1("rst_c_out", host.c_out, 1'b0);
    chk1("rst_a_eq_b", host.a_eq_b, 1'b0);
    chk1("rst_alu_cin", alu.alu_cin, 1'b0);
    chk("rst_alu_a", W'(alu.alu_a), '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h0FFF, 16'h0001, 4'b0101, 1'b0, 1'b0, 0, 1'b0);
    chk("tp_add_result", host.result, 16'h1000);
    chk1("tp_add_c_out", host.c_out, 1'b0);
    run_op(16'h1000, 16'h0001, 4'b1000, 1'b0, 1'b1, 1, 1'b0);
    chk("tp_sub_result", host.result, 16'h0FFF);
    chk1("tp_sub_c_out", host.c_out, 1'b0);
    run_op(16'hA5A5, 16'h5AA5, 4'b0110, 1'b1, 1'b0, 0, 1'b1);
    chk("tp_xor_result", host.result, 16'hFF00);
    run_op(16'h1234, 16'h1234, 4'b0110, 1'b1, 1'b0, 0, 1'b0);
    chk1("tp_eq_a_eq_b", host.a_eq_b, 1'b1);
    run_op(16'h1234, 16'h1235, 4'b0110, 1'b1, 1'b1, 3, 1'b0);
    chk1("tp_neq_a_eq_b", host.a_eq_b, 1'b0);

    // Abort in the middle of RUN at idx=2.
    host.op_a = 16'hFFFF; host.op_b = 16'h0001; host.op_s = 4'b0101;
    host.op_m = 1'b0; host.op_cin = 1'b1;
    host.start = 1'b1;
    @(negedge clk);
    host.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk1("mid_rst_in_ready", host.in_ready, 1'b1);
    chk1("mid_rst_out_valid", host.out_valid, 1'b0);
    chk("mid_rst_result", host.result, '0);
    chk1("mid_rst_c_out", host.c_out, 1'b0);
    chk1("mid_rst_alu_cin", alu.alu_cin, 1'b0);
    run_op(16'h8001, 16'h7FFF, 4'b0101, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_nibble_seq.md
# ula_nibble_seq

Sequencer that time-multiplexes a single 4-bit `ula_74181` slice to perform NIBBLES×4-bit logic and arithmetic operations, least-significant nibble first, one nibble per clock. It latches wide operands on a start handshake and drives the slice's `a`, `b`, `s`, `m` and `c_in` inputs from those latched values. It captures `f`, `c_out` and `a_eq_b` each cycle, chains the carry between nibbles, and returns the wide result on a valid/ready handshake. It sits between the datapath's operand registers and the shared ALU slice.

## Interface
- NIBBLES, 4, number of nibbles per operation (≥1); operand width W = 4·NIBBLES
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when in_ready=1
- in_ready  out  1  1 iff state IDLE
- op_a, op_b  in  W  operands, latched at start acceptance
- op_s  in  4  function select, latched
- op_m  in  1  1 = logic, 0 = arithmetic, latched
- op_cin  in  1  carry into nibble 0 (true-carry sense), latched
- alu_a, alu_b  out  4  current nibble of latched operands
- alu_s, alu_m  out  4/1  latched op_s/op_m
- alu_cin  out  1  chained carry register
- alu_f  in  4  slice result
- alu_cout  in  1  slice carry-out (raw slice convention)
- alu_aeqb  in  1  slice A=B
- result  out  W  assembled result, held until next start acceptance
- c_out  out  1  raw alu_cout of the last nibble; forced 0 in logic mode
- a_eq_b  out  1  AND of alu_aeqb over all nibbles
- out_valid  out  1  result/c_out/a_eq_b valid
- out_ready  in  1  consumer accept

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1. At that edge: latch op_*, set idx=0, carry=op_cin (0 if op_m=1), eq_acc=1, result=0.
- RUN: alu_a=a_reg[4·idx+:4], alu_b likewise; the slice is combinational. Every RUN edge does the following:
  - result[4·idx+:4] ← alu_f
  - eq_acc ← eq_acc & alu_aeqb
  - carry ← true carry
  - idx ← idx+1
- True carry = alu_cout XOR inv. inv=1 for s ∈ {0010,0011,0110,0111,1000,1001,1010,1110,1111} in arithmetic mode, else 0. True carry is forced 0 when m=1.
- RUN → DONE on the edge where idx=NIBBLES−1. At that edge: c_out ← alu_cout (0 if m=1), a_eq_b ← eq_acc & alu_aeqb, out_valid ← 1.
- DONE → IDLE on an edge with out_ready=1. That edge clears out_valid; result, c_out and a_eq_b are held.
- start is ignored outside IDLE. Operand changes after acceptance have no effect.
- In IDLE and DONE, alu_* drive nibble 0 of the latched registers and alu_cin = the carry register. The slice output is ignored in these states.
- Slice functions whose arithmetic does not use c_in (s=0000–0100) still chain: the carry register updates, and the slice ignores it.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, idx=0, all latched registers 0, result=0, c_out=0, a_eq_b=0, out_valid=0, carry=0. in_ready reads 1 after the reset edge.
- Reset mid-RUN or mid-DONE aborts immediately with the same values. No partial result is retained.
- Latency: start accepted at edge E0; out_valid=1 after edge E0+NIBBLES.
- NIBBLES=1: one RUN cycle.
- Handshake: out_valid is held with stable outputs until out_ready=1. out_ready may already be 1 when out_valid rises; the transfer then occurs on the next edge.
- Throughput: the earliest next start is the cycle after the DONE→IDLE edge, giving a period of NIBBLES+2 cycles.
- idx never wraps; it is reloaded to 0 at acceptance.

## Test plan
- Add with carry ripple, NIBBLES=4: op_m=0, op_s=0101, op_cin=0, A=0x0FFF, B=0x0001 → result=0x1000, c_out=0, a_eq_b=0, out_valid exactly 4 cycles after the accept edge.
- Subtraction with inverted-carry chaining: op_s=1000, op_cin=1, A=0x1000, B=0x0001 → result=0x0FFF, c_out=0. Per-nibble alu_cin sequence is 1,0,0,0.
- Logic XOR: op_m=1, op_s=0110, A=0xA5A5, B=0x5AA5 → result=0xFF00, c_out=0, a_eq_b=0. alu_cin is 0 on every RUN cycle.
- Equality: op_m=1, op_s=0110, A=B=0x1234 → result=0x0000, a_eq_b=1. Repeat with B=0x1235 → a_eq_b=0.
- Backpressure and ignored start: hold out_ready=0 for 3 cycles in DONE while pulsing start and changing op_* → outputs stable and in_ready=0. Raise out_ready → IDLE on the next edge, then a new start is accepted.
- Reset mid-RUN: assert rst_n=0 at idx=2 → next edge gives IDLE, out_valid=0, result=0, in_ready=1. A following operation completes correctly.
